// File: rtl/dmem_backing_store.sv
`default_nettype none
// ============================================================================
// Module   : dmem_backing_store
// Purpose  : Word-addressed data memory behind the L2 cache. Refill reads
//            complete after a fixed latency. Write-backs are posted into a
//            small FIFO that drains one entry per cycle into the array. Reads
//            forward from that FIFO, so a refill always returns the newest
//            data. A flush handshake reports when the FIFO is empty.
// Ports    : clk         - clock, all state on posedge
//            reset       - synchronous, active-low reset
//            req_valid   - request present
//            req_we      - 1 = write-back, 0 = refill read
//            req_addr    - byte address (bits [1:0] ignored)
//            req_wdata   - write-back data
//            req_ready   - request is accepted when req_valid && req_ready
//            resp_valid  - one-cycle read-data pulse
//            resp_rdata  - read data, zero outside resp_valid
//            resp_err    - one-cycle pulse for an out-of-range access
//            flush_req   - level request to drain the write buffer
//            flush_done  - one-cycle pulse when the flush completes
//            wb_count    - current write-buffer occupancy
// Revision : 1.0 - initial release
// ============================================================================
module dmem_backing_store #(
    parameter int ADDR_W     = 10,
    parameter int RD_LATENCY = 3,
    parameter int WB_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    input  logic                        req_we,
    input  logic [31:0]                 req_addr,
    input  logic [31:0]                 req_wdata,
    output logic                        req_ready,
    output logic                        resp_valid,
    output logic [31:0]                 resp_rdata,
    output logic                        resp_err,
    input  logic                        flush_req,
    output logic                        flush_done,
    output logic [$clog2(WB_DEPTH):0]   wb_count
);

    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [CNT_W-1:0] WB_FULL  = CNT_W'(WB_DEPTH);
    localparam logic [3:0]       LAT_INIT = 4'(RD_LATENCY - 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_READ_WAIT = 2'd1;
    localparam logic [1:0] S_FLUSH     = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         state_q, state_d;
    logic               ready_en_q;     // holds req_ready low the cycle after reset
    logic [3:0]         lat_q;
    logic [31:0]        snap_data_q;
    logic               snap_err_q;
    logic               resp_valid_q;
    logic [31:0]        resp_rdata_q;
    logic               resp_err_q;
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [CNT_W-1:0]   count_q;
    logic [ADDR_W-1:0]  wb_idx_q  [WB_DEPTH];
    logic [31:0]        wb_data_q [WB_DEPTH];
    logic [31:0]        mem_q     [DEPTH];

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]  w_idx;
    logic               w_oor;
    logic               w_accept, w_rd_acc, w_wr_acc;
    logic               w_push, w_pop, w_rd_done;
    logic               w_fwd_hit;
    logic [31:0]        w_fwd_data;
    logic [31:0]        w_rd_data;
    logic               w_unused_ok;

    assign w_idx       = req_addr[ADDR_W+1:2];
    assign w_oor       = |req_addr[31:ADDR_W+2];
    assign w_unused_ok = ^req_addr[1:0];

    assign w_accept  = req_valid && req_ready;
    assign w_rd_acc  = w_accept && !req_we;
    assign w_wr_acc  = w_accept && req_we;
    assign w_push    = w_wr_acc && !w_oor;
    assign w_pop     = (count_q != '0);
    assign w_rd_done = (state_q == S_READ_WAIT) && (lat_q == 4'd0);

    // Forwarding search walks from oldest to youngest so the youngest match
    // wins. The head entry is still in the buffer during the cycle it drains,
    // so it is covered here even though the array write lands at the edge.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (CNT_W'(i) < count_q) begin
                if (wb_idx_q[head_q + PTR_W'(i)] == w_idx) begin
                    w_fwd_hit  = 1'b1;
                    w_fwd_data = wb_data_q[head_q + PTR_W'(i)];
                end
            end
        end
    end

    always_comb begin
        w_rd_data = mem_q[w_idx];
        if (w_oor) begin
            w_rd_data = '0;
        end else if (w_fwd_hit) begin
            w_rd_data = w_fwd_data;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_rd_acc) begin
                    state_d = S_READ_WAIT;
                end else if (flush_req && !w_accept) begin
                    state_d = S_FLUSH;
                end
            end
            S_READ_WAIT: begin
                if (lat_q == 4'd0) begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (count_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        req_ready  = ready_en_q && (state_q == S_IDLE) && !flush_req &&
                     (count_q < WB_FULL);
        flush_done = (state_q == S_FLUSH) && (count_q == '0);
    end

    // ------------------------------------------------------------------
    // Control and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            ready_en_q   <= 1'b0;
            lat_q        <= 4'd0;
            snap_data_q  <= '0;
            snap_err_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
        end else begin
            ready_en_q <= 1'b1;

            if (w_rd_acc) begin
                lat_q       <= LAT_INIT;
                snap_data_q <= w_rd_data;
                snap_err_q  <= w_oor;
            end else if ((state_q == S_READ_WAIT) && (lat_q != 4'd0)) begin
                lat_q <= lat_q - 4'd1;
            end

            resp_valid_q <= w_rd_done;
            resp_rdata_q <= w_rd_done ? snap_data_q : 32'd0;
            resp_err_q   <= (w_rd_done && snap_err_q) || (w_wr_acc && w_oor);

            if (w_push) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (w_pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // ------------------------------------------------------------------
    // Buffer storage and array; contents survive reset, but no write
    // happens while reset is asserted so un-drained entries are discarded.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            wb_idx_q[tail_q]  <= w_idx;
            wb_data_q[tail_q] <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && w_pop) begin
            mem_q[wb_idx_q[head_q]] <= wb_data_q[head_q];
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign wb_count   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_backing_store.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_backing_store
// Purpose  : Self-checking bench for dmem_backing_store. A plain word array
//            updated at every accepted in-range write gives the value any
//            later read must return.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_backing_store;

    localparam int ADDR_W     = 10;
    localparam int RD_LATENCY = 3;
    localparam int WB_DEPTH   = 4;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we    = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic        flush_req = 1'b0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        flush_done;
    logic [2:0]  wb_count;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    logic [31:0] ref_mem [0:1023];
    bit          written [0:1023];

    dmem_backing_store #(
        .ADDR_W     (ADDR_W),
        .RD_LATENCY (RD_LATENCY),
        .WB_DEPTH   (WB_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .wb_count   (wb_count)
    );

    always #5 clk = ~clk;

    // Invariants checked every cycle once out of the initial reset
    always @(negedge clk) begin
        if (mon_en && reset) begin
            total++;
            if (wb_count > 3'(WB_DEPTH)) begin
                bad++;
                $display("FAIL wb_count_bound: wb_count=%0d limit=%0d", wb_count, WB_DEPTH);
            end
            total++;
            if (resp_valid !== 1'b1 && resp_rdata !== 32'd0) begin
                bad++;
                $display("FAIL rdata_idle_zero: resp_rdata=%h required 0", resp_rdata);
            end
            if (flush_done === 1'b1) begin
                total++;
                if (wb_count !== 3'd0) begin
                    bad++;
                    $display("FAIL flush_done_empty: wb_count=%0d required 0", wb_count);
                end
            end
        end
    end

    // Present a request and hold it until accepted; returns #1 after the
    // accept edge with req_valid dropped.
    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] data, output int waited);
        waited    = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        while (req_ready !== 1'b1 && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL issue_timeout: req_ready=%b required 1", req_ready);
            req_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            if (we && addr[31:12] == 20'd0) begin
                ref_mem[addr[11:2]] = data;
                written[addr[11:2]] = 1'b1;
            end
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input string nm);
        int w;
        logic exp_err;
        exp_err = (addr[31:12] != 20'd0);
        issue(1'b1, addr, data, w);
        total++;
        if (resp_err !== exp_err) begin
            bad++;
            $display("FAIL %s_wr_err: resp_err=%b required %b", nm, resp_err, exp_err);
        end
    endtask

    task automatic check_read(input logic [31:0] addr, input string nm);
        int          w;
        int          seen;
        logic [31:0] got;
        logic        got_err;
        logic        exp_err;
        logic [31:0] exp_data;
        bit          ready_bad;
        exp_err   = (addr[31:12] != 20'd0);
        exp_data  = exp_err ? 32'd0 : ref_mem[addr[11:2]];
        seen      = -1;
        got       = '0;
        got_err   = 1'b0;
        ready_bad = 1'b0;
        issue(1'b0, addr, 32'd0, w);
        for (int k = 0; k <= RD_LATENCY + 2; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (resp_valid === 1'b1 && seen < 0) begin
                seen    = k;
                got     = resp_rdata;
                got_err = resp_err;
            end
            if (k < RD_LATENCY && req_ready !== 1'b0) ready_bad = 1'b1;
        end
        total++;
        if (seen != RD_LATENCY) begin
            bad++;
            $display("FAIL %s_latency: resp_valid at %0d required %0d", nm, seen, RD_LATENCY);
        end
        total++;
        if (got !== exp_data) begin
            bad++;
            $display("FAIL %s_rdata: got %h required %h", nm, got, exp_data);
        end
        total++;
        if (got_err !== exp_err) begin
            bad++;
            $display("FAIL %s_rerr: got %b required %b", nm, got_err, exp_err);
        end
        total++;
        if (ready_bad) begin
            bad++;
            $display("FAIL %s_ready_wait: req_ready=1 required 0 during wait", nm);
        end
    endtask

    task automatic wait_drain(input string nm);
        int k;
        k = 0;
        while (wb_count !== 3'd0 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        total++;
        if (wb_count !== 3'd0) begin
            bad++;
            $display("FAIL %s_drain: wb_count=%0d required 0", nm, wb_count);
        end
    endtask

    task automatic check_outputs_zero(input string nm);
        total++;
        if ({req_ready, resp_valid, resp_err, flush_done} !== 4'b0 ||
            resp_rdata !== 32'd0 || wb_count !== 3'd0) begin
            bad++;
            $display("FAIL %s_outputs: rdy=%b rv=%b rd=%h err=%b fd=%b cnt=%0d required all 0",
                     nm, req_ready, resp_valid, resp_rdata, resp_err, flush_done, wb_count);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: req_ready=%b required 1", req_ready);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_basic_read();
        do_write(32'h0000_0010, 32'hDEAD_BEEF, "basic");
        wait_drain("basic");
        check_read(32'h0000_0010, "basic");
    endtask

    task automatic test_forward();
        for (int i = 1; i <= 4; i++) do_write(32'h0000_0020, 32'(i), "fwd");
        check_read(32'h0000_0020, "fwd_buffered");
        wait_drain("fwd");
        check_read(32'h0000_0020, "fwd_array");
    endtask

    task automatic test_stall_and_stream();
        int          w;
        logic [31:0] a;
        issue(1'b0, 32'h0000_0040, 32'd0, w);
        issue(1'b1, 32'h0000_0048, 32'h1234_5678, w);
        total++;
        if (w != RD_LATENCY) begin
            bad++;
            $display("FAIL stall_wait: waited %0d required %0d", w, RD_LATENCY);
        end
        total++;
        if (wb_count !== 3'd1) begin
            bad++;
            $display("FAIL stall_push: wb_count=%0d required 1", wb_count);
        end
        for (int i = 0; i < 8; i++) begin
            a = 32'h0000_0080 + 32'(i * 4);
            do_write(a, $urandom, "stream");
        end
        wait_drain("stream");
        check_read(32'h0000_0048, "stall_rb");
        for (int i = 0; i < 8; i++) begin
            a = 32'h0000_0080 + 32'(i * 4);
            check_read(a, "stream_rb");
        end
    endtask

    task automatic test_out_of_range();
        do_write(32'h0000_0000, 32'hC0FF_EE00, "oor_base");
        wait_drain("oor_base");
        do_write(32'h0000_1000, 32'hBAD0_BAD0, "oor");
        total++;
        if (wb_count !== 3'd0) begin
            bad++;
            $display("FAIL oor_not_pushed: wb_count=%0d required 0", wb_count);
        end
        @(posedge clk); #1;
        total++;
        if (resp_err !== 1'b0) begin
            bad++;
            $display("FAIL oor_err_pulse: resp_err=%b required 0", resp_err);
        end
        check_read(32'h0000_1000, "oor_rd");
        check_read(32'h0000_0000, "oor_alias");
    endtask

    task automatic test_flush();
        int seen;
        int pulses;
        bit pattern_bad;
        for (int i = 0; i < 3; i++) do_write(32'h0000_00A0 + 32'(i * 4), $urandom, "flush");
        flush_req = 1'b1;
        #1;
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL flush_blocks_ready: req_ready=%b required 0", req_ready);
        end
        seen = -1;
        for (int k = 1; k <= 8 && seen < 0; k++) begin
            @(posedge clk); #1;
            if (flush_done === 1'b1) seen = k;
        end
        total++;
        if (seen < 1 || seen > 4) begin
            bad++;
            $display("FAIL flush_done_time: seen at %0d required 1..4", seen);
        end
        pulses      = 0;
        pattern_bad = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (flush_done === 1'b1) pulses++;
            if (flush_done !== ((k % 2) == 0)) pattern_bad = 1'b1;
            if (req_ready !== 1'b0) pattern_bad = 1'b1;
        end
        total++;
        if (pulses != 3 || pattern_bad) begin
            bad++;
            $display("FAIL flush_retrigger: pulses=%0d required 3 every 2 cycles", pulses);
        end
        flush_req = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) check_read(32'h0000_00A0 + 32'(i * 4), "flush_rb");
    endtask

    task automatic test_reset_mid_op();
        int  w;
        bit  rv_seen;
        do_write(32'h0000_0060, 32'hAAAA_5555, "rst_base");
        wait_drain("rst_base");
        // A buffered write caught by reset must never reach the array
        issue(1'b1, 32'h0000_0060, 32'h5555_AAAA, w);
        ref_mem[10'h018] = 32'hAAAA_5555;
        reset = 1'b0;
        @(posedge clk); #1;
        check_outputs_zero("rst_discard");
        reset = 1'b1;
        issue(1'b0, 32'h0000_0060, 32'd0, w);
        reset = 1'b0;
        @(posedge clk); #1;
        check_outputs_zero("rst_mid_read");
        reset = 1'b1;
        rv_seen = 1'b0;
        for (int k = 0; k < RD_LATENCY + 3; k++) begin
            @(posedge clk); #1;
            if (resp_valid === 1'b1) rv_seen = 1'b1;
        end
        total++;
        if (rv_seen) begin
            bad++;
            $display("FAIL rst_abort_read: resp_valid=1 required 0");
        end
        check_read(32'h0000_0060, "rst_rb");
    endtask

    task automatic test_random();
        int          r;
        logic [9:0]  idx;
        logic [31:0] a;
        for (int n = 0; n < 80; n++) begin
            r   = $urandom_range(0, 9);
            idx = 10'(200 + $urandom_range(0, 7));
            a   = {20'd0, idx, 2'b00};
            if (r < 5 || !written[idx]) begin
                if (r == 4) a = a | 32'h0000_1000;
                do_write(a, $urandom, "rnd");
            end else if (r < 8) begin
                check_read(a, "rnd");
            end else if (r == 8) begin
                check_read(a | 32'h8000_0000, "rnd_oor");
            end else begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk); #1;
                end
            end
        end
        wait_drain("rnd");
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = '0;
            written[i] = 1'b0;
        end
        test_reset();
        test_basic_read();
        test_forward();
        test_stall_and_stream();
        test_out_of_range();
        test_flush();
        test_reset_mid_op();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
